lpi_sram_ctrl: RTL and testbench

Terminal stage behind the AXI-to-LPI slave bridge. It consumes the bridge's split LPI channels (write address, write data, write response, read address, read data) and drives a single-port synchronous SRAM with 1-cycle read latency. Read and write share the SRAM port under round-robin arbitration. A 2-entry read-response buffer keeps one read per cycle under backpressure, and out-of-range accesses complete with SLVERR.

---
 rtl/lpi_sram_ctrl_if.sv | 55 +++++
 rtl/lpi_sram_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_lpi_sram_ctrl.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpi_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lpi_sram_ctrl_if
// Description : Split LPI channel bundle between the AXI-to-LPI bridge
//               (master) and the SRAM controller (slave): write address,
//               write data, write response, read address and read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface lpi_sram_ctrl_if #(
    parameter int BW_ADDR = 32,
    parameter int BW_DATA = 32
) ();
    localparam int BW_STRB = BW_DATA / 8;

    // Write address / write data channels
    logic [BW_ADDR-1:0] sawaddr;
    logic               sawvalid;
    logic               sawready;
    logic [BW_DATA-1:0] swdata;
    logic [BW_STRB-1:0] swstrb;
    logic               swvalid;
    logic               swready;

    // Write response channel
    logic [1:0]         sbresp;
    logic               sbvalid;
    logic               sbready;

    // Read address / read data channels
    logic [BW_ADDR-1:0] saraddr;
    logic               sarvalid;
    logic               sarready;
    logic [BW_DATA-1:0] srdata;
    logic [1:0]         srresp;
    logic               srvalid;
    logic               srready;

    // Bridge side
    modport master (
        output sawaddr, sawvalid, swdata, swstrb, swvalid, sbready,
        output saraddr, sarvalid, srready,
        input  sawready, swready, sbresp, sbvalid,
        input  sarready, srdata, srresp, srvalid
    );

    // Controller side
    modport slave (
        input  sawaddr, sawvalid, swdata, swstrb, swvalid, sbready,
        input  saraddr, sarvalid, srready,
        output sawready, swready, sbresp, sbvalid,
        output sarready, srdata, srresp, srvalid
    );
endinterface

`default_nettype wire

// File: rtl/lpi_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lpi_sram_ctrl
// Description : Terminal LPI stage driving a single-port synchronous SRAM
//               (1-cycle read latency). Reads and writes share the port
//               under round-robin arbitration; a 2-entry read-response FIFO
//               sustains one read per cycle under backpressure; accesses
//               beyond MEM_DEPTH complete with SLVERR and touch no memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lpi_sram_ctrl #(
    parameter  int BW_ADDR      = 32,
    parameter  int BW_DATA      = 32,
    parameter  int MEM_DEPTH    = 1024,
    localparam int BW_SRAM_ADDR = $clog2(MEM_DEPTH),
    localparam int BW_STRB      = BW_DATA / 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    lpi_sram_ctrl_if.slave               lpi,
    output logic                         sram_sel,
    output logic                         sram_we,
    output logic [BW_SRAM_ADDR-1:0]      sram_addr,
    output logic [BW_DATA-1:0]           sram_wdata,
    output logic [BW_STRB-1:0]           sram_be,
    input  wire logic [BW_DATA-1:0]      sram_rdata
);

    // Byte-offset bits below the word index, and width of the full word address
    localparam int c_OFF     = $clog2(BW_STRB);
    localparam int c_BW_WORD = BW_ADDR - c_OFF;

    localparam logic [BW_ADDR:0] c_DEPTH       = (BW_ADDR+1)'(MEM_DEPTH);
    localparam logic [1:0]       c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]       c_RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_inflight;        // read granted last cycle, data due now
    logic [1:0]          r_inflight_resp;
    logic                r_last_rd;         // 1: last grant went to the read side
    logic [BW_DATA-1:0]  r_fifo_data [0:1];
    logic [1:0]          r_fifo_resp [0:1];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [c_BW_WORD-1:0] w_wr_word;
    logic [c_BW_WORD-1:0] w_rd_word;
    logic                 w_wr_oor;
    logic                 w_rd_oor;
    logic [1:0]           w_credit;
    logic                 w_pop;
    logic                 w_push;
    logic [BW_DATA-1:0]   w_push_data;
    logic                 w_wr_elig;
    logic                 w_rd_elig;
    logic                 w_gnt_wr;
    logic                 w_gnt_rd;

    // Word address: byte offset dropped; every remaining bit joins the range check
    assign w_wr_word = lpi.sawaddr[BW_ADDR-1:c_OFF];
    assign w_rd_word = lpi.saraddr[BW_ADDR-1:c_OFF];
    assign w_wr_oor  = {{(c_OFF+1){1'b0}}, w_wr_word} >= c_DEPTH;
    assign w_rd_oor  = {{(c_OFF+1){1'b0}}, w_rd_word} >= c_DEPTH;

    // Byte-offset bits are intentionally ignored
    generate
        if (c_OFF > 0) begin : g_unused_offset
            logic w_unused_offset;
            assign w_unused_offset = ^{lpi.sawaddr[c_OFF-1:0], lpi.saraddr[c_OFF-1:0]};
        end
    endgenerate

    // Read credit counts the read in flight plus buffered responses
    assign w_pop     = (r_count != 2'd0) && lpi.srready;
    assign w_push    = r_inflight;
    assign w_credit  = r_count + {1'b0, r_inflight};
    assign w_push_data = (r_inflight_resp == c_RESP_OKAY) ? sram_rdata : '0;

    // Eligibility; nothing is granted while reset is asserted
    assign w_wr_elig = !rst && lpi.sawvalid && lpi.swvalid && (!r_bvalid || lpi.sbready);
    assign w_rd_elig = !rst && lpi.sarvalid && ((w_credit < 2'd2) || w_pop);

    // Round-robin grant: on a tie, the side not granted last time wins
    always_comb begin
        w_gnt_rd = 1'b0;
        w_gnt_wr = 1'b0;
        if (w_rd_elig && w_wr_elig) begin
            if (r_last_rd) begin
                w_gnt_wr = 1'b1;
            end else begin
                w_gnt_rd = 1'b1;
            end
        end else begin
            w_gnt_rd = w_rd_elig;
            w_gnt_wr = w_wr_elig;
        end
    end

    // SRAM strobe: only in-range granted accesses reach the memory
    always_comb begin
        sram_sel   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_be    = '0;
        if (w_gnt_wr && !w_wr_oor) begin
            sram_sel   = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = w_wr_word[BW_SRAM_ADDR-1:0];
            sram_wdata = lpi.swdata;
            sram_be    = lpi.swstrb;
        end else if (w_gnt_rd && !w_rd_oor) begin
            sram_sel   = 1'b1;
            sram_addr  = w_rd_word[BW_SRAM_ADDR-1:0];
            sram_be    = '1;
        end
    end

    // LPI outputs: readies mirror the grant, responses come from registers
    assign lpi.sawready = w_gnt_wr;
    assign lpi.swready  = w_gnt_wr;
    assign lpi.sarready = w_gnt_rd;
    assign lpi.sbvalid  = r_bvalid;
    assign lpi.sbresp   = r_bresp;
    assign lpi.srvalid  = (r_count != 2'd0);
    assign lpi.srdata   = r_fifo_data[r_rd_ptr];
    assign lpi.srresp   = r_fifo_resp[r_rd_ptr];

    // Write response register: load on write grant, hold until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= c_RESP_OKAY;
        end else if (w_gnt_wr) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_oor ? c_RESP_SLVERR : c_RESP_OKAY;
        end else if (lpi.sbready) begin
            r_bvalid <= 1'b0;
        end
    end

    // In-flight read tracker: one cycle between grant and SRAM data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight      <= 1'b0;
            r_inflight_resp <= c_RESP_OKAY;
        end else begin
            r_inflight <= w_gnt_rd;
            if (w_gnt_rd) begin
                r_inflight_resp <= w_rd_oor ? c_RESP_SLVERR : c_RESP_OKAY;
            end
        end
    end

    // Last-grant pointer for round-robin
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_rd <= 1'b0;
        end else if (w_gnt_rd || w_gnt_wr) begin
            r_last_rd <= w_gnt_rd;
        end
    end

    // Read-response FIFO: push the captured read, pop on consumer handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_resp[0] <= c_RESP_OKAY;
            r_fifo_resp[1] <= c_RESP_OKAY;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_resp[r_wr_ptr] <= r_inflight_resp;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lpi_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpi_sram_ctrl
// Description : Self-checking bench for lpi_sram_ctrl. A behavioural SRAM
//               model answers the memory port; a shadow memory plus response
//               queues predict every LPI response from address/strobe rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpi_sram_ctrl;

    localparam int BW_ADDR   = 32;
    localparam int BW_DATA   = 32;
    localparam int MEM_DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lpi_sram_ctrl_if #(.BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA)) bus ();

    logic        sram_sel;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_be;
    bit   [31:0] sram_rdata;

    lpi_sram_ctrl #(
        .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .lpi(bus),
        .sram_sel(sram_sel), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_be(sram_be), .sram_rdata(sram_rdata)
    );

    // Behavioural single-port SRAM, 1-cycle read latency
    bit [31:0] sram_mem [0:MEM_DEPTH-1];
    always @(posedge clk) begin
        if (sram_sel) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: shadow memory and response queues
    bit   [31:0] shadow [0:MEM_DEPTH-1];
    logic [31:0] exp_rd_data [$];
    logic [1:0]  exp_rd_resp [$];
    logic [31:0] obs_rd_data [$];
    logic [1:0]  obs_rd_resp [$];
    logic [1:0]  exp_b [$];
    logic [1:0]  obs_b [$];

    int tests_run    = 0;
    int tests_failed = 0;

    // One clock: record handshakes into the model at the falling edge,
    // then return just after the next rising edge.
    task automatic step();
        logic [31:0] w;
        @(negedge clk);
        if (!rst) begin
            if (bus.sawvalid && bus.sawready) begin
                w = bus.sawaddr >> 2;
                if (w >= MEM_DEPTH) begin
                    exp_b.push_back(2'b10);
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (bus.swstrb[b]) shadow[w][8*b +: 8] = bus.swdata[8*b +: 8];
                    exp_b.push_back(2'b00);
                end
            end
            if (bus.sarvalid && bus.sarready) begin
                w = bus.saraddr >> 2;
                if (w >= MEM_DEPTH) begin
                    exp_rd_data.push_back(32'h0);
                    exp_rd_resp.push_back(2'b10);
                end else begin
                    exp_rd_data.push_back(shadow[w]);
                    exp_rd_resp.push_back(2'b00);
                end
            end
            if (bus.srvalid && bus.srready) begin
                obs_rd_data.push_back(bus.srdata);
                obs_rd_resp.push_back(bus.srresp);
            end
            if (bus.sbvalid && bus.sbready) obs_b.push_back(bus.sbresp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_rd_data.delete(); exp_rd_resp.delete();
        obs_rd_data.delete(); obs_rd_resp.delete();
        exp_b.delete(); obs_b.delete();
    endtask

    task automatic idle_inputs();
        bus.sawaddr = '0; bus.sawvalid = 1'b0; bus.swdata = '0; bus.swstrb = '0;
        bus.swvalid = 1'b0; bus.sbready = 1'b0; bus.saraddr = '0;
        bus.sarvalid = 1'b0; bus.srready = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        case ($urandom_range(0, 7))
            0:       w = $urandom_range(1020, 1100);
            1:       w = $urandom;
            default: w = $urandom_range(0, 15);
        endcase
        return (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Full write transaction with bounded waits (stimulus only)
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        bit got = 0;
        ok = 0; resp = 2'bxx;
        bus.sawaddr = addr; bus.swdata = data; bus.swstrb = strb;
        bus.sawvalid = 1'b1; bus.swvalid = 1'b1; bus.sbready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin #1; got = bus.sawready; step(); end
        bus.sawvalid = 1'b0; bus.swvalid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.sbvalid) begin ok = got; resp = bus.sbresp; end
            step();
        end
        bus.sbready = 1'b0;
    endtask

    // Full read transaction with bounded waits (stimulus only)
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        bit got = 0;
        ok = 0; data = 'x; resp = 2'bxx;
        bus.saraddr = addr; bus.sarvalid = 1'b1; bus.srready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin #1; got = bus.sarready; step(); end
        bus.sarvalid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.srvalid) begin ok = got; data = bus.srdata; resp = bus.srresp; end
            step();
        end
        bus.srready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.sawvalid = 1'b1; bus.swvalid = 1'b1; bus.swstrb = 4'hF; bus.sarvalid = 1'b1;
        #1;
        tests_run++;
        if ({bus.sawready, bus.swready, bus.sarready} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ready: got %b required 000", {bus.sawready, bus.swready, bus.sarready});
        end
        step(); step();
        tests_run++;
        if ({sram_sel, sram_we} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_sram: sel/we got %b required 00", {sram_sel, sram_we});
        end
        tests_run++;
        if ({bus.sbvalid, bus.srvalid, bus.sbresp, bus.srresp} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_resp: got %b required 000000", {bus.sbvalid, bus.srvalid, bus.sbresp, bus.srresp});
        end
        tests_run++;
        if (bus.srdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_srdata: got %h required 0", bus.srdata);
        end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_write_read();
        bus.sawaddr = 32'h10; bus.swdata = 32'hDEADBEEF; bus.swstrb = 4'hF;
        bus.sawvalid = 1'b1; bus.swvalid = 1'b1; bus.sbready = 1'b0;
        #1;
        tests_run++;
        if ({bus.sawready, bus.swready, sram_sel, sram_we, sram_addr, sram_be, sram_wdata} !==
            {4'b1111, 10'd4, 4'hF, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL wr_grant: rdy=%b%b sel=%b we=%b addr=%0d be=%h wd=%h required 1 1 1 1 4 f deadbeef",
                     bus.sawready, bus.swready, sram_sel, sram_we, sram_addr, sram_be, sram_wdata);
        end
        step();
        bus.sawvalid = 1'b0; bus.swvalid = 1'b0;
        tests_run++;
        if ({bus.sbvalid, bus.sbresp} !== 3'b100) begin
            tests_failed++; $display("FAIL wr_resp_t1: valid/resp got %b required 100", {bus.sbvalid, bus.sbresp});
        end
        bus.sbready = 1'b1;
        step();
        bus.sbready = 1'b0;
        tests_run++;
        if (bus.sbvalid !== 1'b0) begin
            tests_failed++; $display("FAIL wr_resp_drop: sbvalid got %b required 0", bus.sbvalid);
        end
        bus.saraddr = 32'h10; bus.sarvalid = 1'b1; bus.srready = 1'b0;
        #1;
        tests_run++;
        if ({bus.sarready, sram_sel, sram_we, sram_addr, sram_be} !== {3'b110, 10'd4, 4'hF}) begin
            tests_failed++;
            $display("FAIL rd_grant: rdy=%b sel=%b we=%b addr=%0d be=%h required 1 1 0 4 f",
                     bus.sarready, sram_sel, sram_we, sram_addr, sram_be);
        end
        step();
        bus.sarvalid = 1'b0;
        tests_run++;
        if (bus.srvalid !== 1'b0) begin
            tests_failed++; $display("FAIL rd_t1: srvalid got %b required 0", bus.srvalid);
        end
        step();
        tests_run++;
        if ({bus.srvalid, bus.srresp, bus.srdata} !== {3'b100, 32'hDEADBEEF}) begin
            tests_failed++; $display("FAIL rd_t2: valid=%b resp=%b data=%h required 1 00 deadbeef",
                                     bus.srvalid, bus.srresp, bus.srdata);
        end
        bus.srready = 1'b1;
        step();
        bus.srready = 1'b0;
    endtask

    task automatic test_partial();
        logic [31:0] d; logic [1:0] r; bit ok;
        bus.sawaddr = 32'h13; bus.swdata = 32'h0000AB00; bus.swstrb = 4'b0010;
        bus.sawvalid = 1'b1; bus.swvalid = 1'b1; bus.sbready = 1'b1;
        #1;
        tests_run++;
        if ({bus.sawready, sram_be, sram_addr} !== {1'b1, 4'b0010, 10'd4}) begin
            tests_failed++; $display("FAIL partial_be: rdy=%b be=%b addr=%0d required 1 0010 4",
                                     bus.sawready, sram_be, sram_addr);
        end
        step();
        bus.sawvalid = 1'b0; bus.swvalid = 1'b0;
        step();
        bus.sbready = 1'b0;
        bus_read(32'h10, d, r, ok);
        tests_run++;
        if (!ok || d !== 32'hDEADABEF || r !== 2'b00) begin
            tests_failed++; $display("FAIL partial_readback: ok=%0d data=%h resp=%b required deadabef 00", ok, d, r);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; bit ok;
        bus.sawaddr = 32'h1000; bus.swdata = $urandom; bus.swstrb = 4'hF;
        bus.sawvalid = 1'b1; bus.swvalid = 1'b1; bus.sbready = 1'b1;
        #1;
        tests_run++;
        if ({bus.sawready, sram_sel} !== 2'b10) begin
            tests_failed++; $display("FAIL oor_wr_sel: rdy/sel got %b required 10", {bus.sawready, sram_sel});
        end
        step();
        bus.sawvalid = 1'b0; bus.swvalid = 1'b0;
        tests_run++;
        if ({bus.sbvalid, bus.sbresp} !== 3'b110) begin
            tests_failed++; $display("FAIL oor_wr_resp: valid/resp got %b required 110", {bus.sbvalid, bus.sbresp});
        end
        step();
        bus.sbready = 1'b0;
        bus_read(32'h2000, d, r, ok);
        tests_run++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            tests_failed++; $display("FAIL oor_rd: ok=%0d data=%h resp=%b required 0 10", ok, d, r);
        end
        bus_read(32'h0, d, r, ok);
        tests_run++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin
            tests_failed++; $display("FAIL oor_no_alias: ok=%0d data=%h resp=%b required 0 00", ok, d, r);
        end
        bus_read(32'h8000_0010, d, r, ok);
        tests_run++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            tests_failed++; $display("FAIL oor_high_bits: ok=%0d data=%h resp=%b required 0 10", ok, d, r);
        end
        bus_write(32'hFFC, 32'hCAFEF00D, 4'hF, r, ok);
        bus_read(32'hFFC, d, r, ok);
        tests_run++;
        if (!ok || d !== 32'hCAFEF00D || r !== 2'b00) begin
            tests_failed++; $display("FAIL last_word: ok=%0d data=%h resp=%b required cafef00d 00", ok, d, r);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        clear_model();
        bus.srready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.saraddr = 32'(i * 4); bus.sarvalid = 1'b1;
            #1;
            tests_run++;
            if (bus.sarready !== 1'b1) begin
                tests_failed++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, bus.sarready);
            end
            step();
        end
        bus.sarvalid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        // Backpressure: only two reads may be outstanding
        bus.srready = 1'b0; bus.sarvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.saraddr = rand_addr();
            #1;
            if (bus.sarready === 1'b1) accepts++;
            step();
        end
        tests_run++;
        if (accepts !== 2) begin
            tests_failed++; $display("FAIL bp_accepts: got %0d required 2", accepts);
        end
        bus.srready = 1'b1;
        #1;
        tests_run++;
        if (bus.sarready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_pop_grant: sarready got %b required 1", bus.sarready);
        end
        step();
        bus.sarvalid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bus.srready = 1'b0;
        tests_run++;
        if (obs_rd_data.size() !== 11 || exp_rd_data.size() !== 11) begin
            tests_failed++; $display("FAIL b2b_count: observed %0d predicted %0d required 11",
                                     obs_rd_data.size(), exp_rd_data.size());
        end
        for (int i = 0; i < exp_rd_data.size() && i < obs_rd_data.size(); i++) begin
            tests_run++;
            if ({obs_rd_resp[i], obs_rd_data[i]} !== {exp_rd_resp[i], exp_rd_data[i]}) begin
                tests_failed++; $display("FAIL b2b_rsp[%0d]: got %b/%h required %b/%h", i,
                                         obs_rd_resp[i], obs_rd_data[i], exp_rd_resp[i], exp_rd_data[i]);
            end
        end
    endtask

    task automatic test_alternate();
        rst = 1'b1; idle_inputs(); step(); rst = 1'b0;
        clear_model();
        bus.srready = 1'b1; bus.sbready = 1'b1;
        bus.sawvalid = 1'b1; bus.swvalid = 1'b1; bus.sarvalid = 1'b1; bus.swstrb = 4'hF;
        for (int i = 0; i < 8; i++) begin
            bus.sawaddr = 32'($urandom_range(0, 15)) << 2; bus.swdata = $urandom;
            bus.saraddr = 32'($urandom_range(0, 15)) << 2;
            #1;
            tests_run++;
            if (bus.sarready !== ((i % 2) == 0) || bus.sawready !== ((i % 2) == 1)) begin
                tests_failed++; $display("FAIL alt_grant[%0d]: r=%b w=%b required r=%0d w=%0d", i,
                                         bus.sarready, bus.sawready, (i % 2) == 0, (i % 2) == 1);
            end
            step();
        end
        // Response consumer toggling: writes must stall, not drop
        for (int i = 0; i < 24; i++) begin
            bus.sbready = 1'($urandom_range(0, 1));
            bus.sawaddr = 32'($urandom_range(0, 15)) << 2; bus.swdata = $urandom;
            bus.saraddr = 32'($urandom_range(0, 15)) << 2;
            #1;
            if (bus.sawready === 1'b1 && bus.sbvalid === 1'b1 && bus.sbready === 1'b0) begin
                tests_run++; tests_failed++;
                $display("FAIL alt_stall[%0d]: write granted while response blocked", i);
            end
            step();
        end
        bus.sawvalid = 1'b0; bus.swvalid = 1'b0; bus.sarvalid = 1'b0; bus.sbready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle_inputs();
        tests_run++;
        if (obs_b.size() !== exp_b.size() || exp_b.size() < 8) begin
            tests_failed++; $display("FAIL alt_bcount: observed %0d predicted %0d", obs_b.size(), exp_b.size());
        end
        tests_run++;
        if (obs_rd_data.size() !== exp_rd_data.size()) begin
            tests_failed++; $display("FAIL alt_rcount: observed %0d predicted %0d", obs_rd_data.size(), exp_rd_data.size());
        end
        for (int i = 0; i < exp_rd_data.size() && i < obs_rd_data.size(); i++) begin
            tests_run++;
            if ({obs_rd_resp[i], obs_rd_data[i]} !== {exp_rd_resp[i], exp_rd_data[i]}) begin
                tests_failed++; $display("FAIL alt_rsp[%0d]: got %b/%h required %b/%h", i,
                                         obs_rd_resp[i], obs_rd_data[i], exp_rd_resp[i], exp_rd_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0; bit got = 0;
        logic [31:0] exp_a;
        bus.srready = 1'b0; bus.sbready = 1'b0;
        bus.sarvalid = 1'b1;
        for (int i = 0; i < 10 && n < 2; i++) begin
            bus.saraddr = 32'($urandom_range(0, 15)) << 2;
            #1; if (bus.sarready === 1'b1) n++;
            step();
        end
        bus.sarvalid = 1'b0;
        bus.sawaddr = 32'h40; bus.swdata = $urandom; bus.swstrb = 4'hF;
        bus.sawvalid = 1'b1; bus.swvalid = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin #1; got = bus.sawready; step(); end
        bus.sawvalid = 1'b0; bus.swvalid = 1'b0;
        step();
        tests_run++;
        if ({bus.srvalid, bus.sbvalid} !== 2'b11) begin
            tests_failed++; $display("FAIL rstmid_pre: srvalid/sbvalid got %b required 11", {bus.srvalid, bus.sbvalid});
        end
        rst = 1'b1; step(); rst = 1'b0;
        tests_run++;
        if ({bus.srvalid, bus.sbvalid} !== 2'b00) begin
            tests_failed++; $display("FAIL rstmid_clear: srvalid/sbvalid got %b required 00", {bus.srvalid, bus.sbvalid});
        end
        clear_model();
        exp_a = shadow[4];
        // Two reads back to back with no consumer: both accepted only if credit was cleared
        bus.saraddr = 32'h10; bus.sarvalid = 1'b1;
        #1; n = (bus.sarready === 1'b1) ? 1 : 0;
        step();
        bus.saraddr = 32'h0;
        #1; if (bus.sarready === 1'b1) n++;
        step();
        bus.sarvalid = 1'b0;
        tests_run++;
        if (n !== 2) begin
            tests_failed++; $display("FAIL rstmid_credit: accepts got %0d required 2", n);
        end
        tests_run++;
        if ({bus.srvalid, bus.srresp, bus.srdata} !== {3'b100, exp_a}) begin
            tests_failed++; $display("FAIL rstmid_t2: valid=%b resp=%b data=%h required 1 00 %h",
                                     bus.srvalid, bus.srresp, bus.srdata, exp_a);
        end
        bus.srready = 1'b1; bus.sbready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle_inputs();
    endtask

    task automatic test_random();
        clear_model();
        for (int i = 0; i < 400; i++) begin
            bus.sawaddr  = rand_addr();  bus.swdata = $urandom; bus.swstrb = 4'($urandom);
            bus.saraddr  = rand_addr();
            bus.sawvalid = 1'($urandom_range(0, 1)); bus.swvalid = bus.sawvalid;
            bus.sarvalid = 1'($urandom_range(0, 1));
            bus.srready  = ($urandom_range(0, 3) != 0); bus.sbready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.sarready === 1'b1 && bus.sawready === 1'b1) begin
                tests_run++; tests_failed++;
                $display("FAIL rand_exclusive[%0d]: read and write granted together", i);
            end
            step();
        end
        idle_inputs();
        bus.srready = 1'b1; bus.sbready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        idle_inputs();
        tests_run++;
        if (obs_rd_data.size() !== exp_rd_data.size() || obs_b.size() !== exp_b.size()) begin
            tests_failed++; $display("FAIL rand_counts: reads %0d/%0d writes %0d/%0d (observed/predicted)",
                                     obs_rd_data.size(), exp_rd_data.size(), obs_b.size(), exp_b.size());
        end
        for (int i = 0; i < exp_rd_data.size() && i < obs_rd_data.size(); i++) begin
            tests_run++;
            if ({obs_rd_resp[i], obs_rd_data[i]} !== {exp_rd_resp[i], exp_rd_data[i]}) begin
                tests_failed++; $display("FAIL rand_rsp[%0d]: got %b/%h required %b/%h", i,
                                         obs_rd_resp[i], obs_rd_data[i], exp_rd_resp[i], exp_rd_data[i]);
            end
        end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            tests_run++;
            if (obs_b[i] !== exp_b[i]) begin
                tests_failed++; $display("FAIL rand_bresp[%0d]: got %b required %b", i, obs_b[i], exp_b[i]);
            end
        end
    endtask

    // Hard time limit so the run always ends
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_out_of_range();
        test_back_to_back();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
